// File: rtl/axis_insert_header_arb.sv
// axis_insert_header_arb
//
// Round-robin packet scheduler placed directly upstream of a shared
// axi_stream_insert_header engine. Each of NUM_SRC requesters offers a
// header (insert channel) and a packet (data channel). A pending header is
// the request. Once a requester is granted, both of its channels are
// forwarded combinationally to the engine until the header and the last
// data beat have each been accepted; the grant is then released.
//
// Ports
//   clk, rst_n                    single clock, synchronous active-low reset
//   s_valid_in/s_data_in/s_keep_in/s_last_in/s_ready_in
//                                 per-source data channels (packed by source)
//   s_valid_insert/s_header_insert/s_keep_insert/s_ready_insert
//                                 per-source header channels (packed by source)
//   m_valid_in/m_data_in/m_keep_in/m_last_in/m_ready_in
//                                 engine data input
//   m_valid_insert/m_header_insert/m_keep_insert/m_ready_insert
//                                 engine header input
//   busy                          a grant is held
//   grant_id                      current or last granted source
//   pkt_count                     completed packets, wraps at 16 bits
module axis_insert_header_arb #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int NUM_SRC      = 4,
    parameter int SRC_WD       = $clog2(NUM_SRC)
) (
    input  logic                            clk,
    input  logic                            rst_n,

    input  logic [NUM_SRC-1:0]              s_valid_in,
    input  logic [NUM_SRC*DATA_WD-1:0]      s_data_in,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_in,
    input  logic [NUM_SRC-1:0]              s_last_in,
    output logic [NUM_SRC-1:0]              s_ready_in,

    input  logic [NUM_SRC-1:0]              s_valid_insert,
    input  logic [NUM_SRC*DATA_WD-1:0]      s_header_insert,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_insert,
    output logic [NUM_SRC-1:0]              s_ready_insert,

    output logic                            m_valid_in,
    output logic [DATA_WD-1:0]              m_data_in,
    output logic [DATA_BYTE_WD-1:0]         m_keep_in,
    output logic                            m_last_in,
    input  logic                            m_ready_in,

    output logic                            m_valid_insert,
    output logic [DATA_WD-1:0]              m_header_insert,
    output logic [DATA_BYTE_WD-1:0]         m_keep_insert,
    input  logic                            m_ready_insert,

    output logic                            busy,
    output logic [SRC_WD-1:0]               grant_id,
    output logic [15:0]                     pkt_count
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    localparam logic [SRC_WD:0]   NUM_SRC_W = (SRC_WD + 1)'(NUM_SRC);
    localparam logic [SRC_WD-1:0] LAST_ID   = SRC_WD'(NUM_SRC - 1);

    state_e              state_q, state_d;
    logic [SRC_WD-1:0]   grant_q, grant_d;
    logic [SRC_WD-1:0]   rr_ptr_q, rr_ptr_d;
    logic                hdr_done_q, hdr_done_d;
    logic                last_done_q, last_done_d;
    logic [15:0]         pkt_cnt_q, pkt_cnt_d;

    // Per-source views of the packed buses
    logic [DATA_WD-1:0]      data_arr [NUM_SRC];
    logic [DATA_BYTE_WD-1:0] keep_arr [NUM_SRC];
    logic [DATA_WD-1:0]      hdr_arr  [NUM_SRC];
    logic [DATA_BYTE_WD-1:0] hkeep_arr[NUM_SRC];

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            data_arr[i]  = s_data_in[i*DATA_WD +: DATA_WD];
            keep_arr[i]  = s_keep_in[i*DATA_BYTE_WD +: DATA_BYTE_WD];
            hdr_arr[i]   = s_header_insert[i*DATA_WD +: DATA_WD];
            hkeep_arr[i] = s_keep_insert[i*DATA_BYTE_WD +: DATA_BYTE_WD];
        end
    end

    // Round-robin search: rotate the request vector so bit 0 is rr_ptr,
    // take the first set bit, then map the offset back to a source index
    // with an explicit wrap (works for non-power-of-2 NUM_SRC).
    logic [NUM_SRC-1:0] rot_req;
    logic               win_vld;
    logic [SRC_WD-1:0]  win_id;
    logic [SRC_WD:0]    win_sum;

    always_comb begin
        rot_req = NUM_SRC'({s_valid_insert, s_valid_insert} >> rr_ptr_q);
        win_vld = 1'b0;
        win_sum = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!win_vld && rot_req[k]) begin
                win_vld = 1'b1;
                win_sum = {1'b0, rr_ptr_q} + (SRC_WD + 1)'(k);
                if (win_sum >= NUM_SRC_W) begin
                    win_sum = win_sum - NUM_SRC_W;
                end
            end
        end
        win_id = win_sum[SRC_WD-1:0];
    end

    // Forwarding paths: each channel stays open until its own handshake
    // has completed, so a second header or a beat after last is held off.
    logic hdr_open, data_open;
    logic hdr_fire, last_fire, pkt_done;

    always_comb begin
        hdr_open        = (state_q == ACTIVE) && !hdr_done_q;
        data_open       = (state_q == ACTIVE) && !last_done_q;

        m_valid_insert  = 1'b0;
        m_header_insert = '0;
        m_keep_insert   = '0;
        s_ready_insert  = '0;
        m_valid_in      = 1'b0;
        m_data_in       = '0;
        m_keep_in       = '0;
        m_last_in       = 1'b0;
        s_ready_in      = '0;

        if (hdr_open) begin
            m_valid_insert           = s_valid_insert[grant_q];
            m_header_insert          = hdr_arr[grant_q];
            m_keep_insert            = hkeep_arr[grant_q];
            s_ready_insert[grant_q]  = m_ready_insert;
        end
        if (data_open) begin
            m_valid_in               = s_valid_in[grant_q];
            m_data_in                = data_arr[grant_q];
            m_keep_in                = keep_arr[grant_q];
            m_last_in                = s_last_in[grant_q];
            s_ready_in[grant_q]      = m_ready_in;
        end

        hdr_fire  = m_valid_insert && m_ready_insert;
        last_fire = m_valid_in && m_ready_in && m_last_in;
        // Flags completing in the current cycle count toward release.
        pkt_done  = (state_q == ACTIVE) &&
                    (hdr_done_q || hdr_fire) && (last_done_q || last_fire);
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        hdr_done_d  = hdr_done_q;
        last_done_d = last_done_q;
        pkt_cnt_d   = pkt_cnt_q;

        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d     = ACTIVE;
                    grant_d     = win_id;
                    rr_ptr_d    = (win_id == LAST_ID) ? '0 : win_id + SRC_WD'(1);
                    hdr_done_d  = 1'b0;
                    last_done_d = 1'b0;
                end
            end
            ACTIVE: begin
                hdr_done_d  = hdr_done_q || hdr_fire;
                last_done_d = last_done_q || last_fire;
                if (pkt_done) begin
                    state_d     = IDLE;
                    hdr_done_d  = 1'b0;
                    last_done_d = 1'b0;
                    pkt_cnt_d   = pkt_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            hdr_done_q  <= 1'b0;
            last_done_q <= 1'b0;
            pkt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            hdr_done_q  <= hdr_done_d;
            last_done_q <= last_done_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    assign busy      = (state_q == ACTIVE);
    assign grant_id  = grant_q;
    assign pkt_count = pkt_cnt_q;

endmodule

// File: tb/tb_axis_insert_header_arb.sv
module tb_axis_insert_header_arb;

    localparam int DW  = 32;
    localparam int BW  = 4;
    localparam int NS  = 4;
    localparam int SW  = 2;
    localparam int NS3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Four-source instance
    logic [NS-1:0]    s_valid_in, s_last_in, s_ready_in, s_valid_insert, s_ready_insert;
    logic [NS*DW-1:0] s_data_in, s_header_insert;
    logic [NS*BW-1:0] s_keep_in, s_keep_insert;
    logic             m_valid_in, m_last_in, m_ready_in, m_valid_insert, m_ready_insert, busy;
    logic [DW-1:0]    m_data_in, m_header_insert;
    logic [BW-1:0]    m_keep_in, m_keep_insert;
    logic [SW-1:0]    grant_id;
    logic [15:0]      pkt_count;

    axis_insert_header_arb #(.DATA_WD(DW), .NUM_SRC(NS)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid_in(s_valid_in), .s_data_in(s_data_in), .s_keep_in(s_keep_in),
        .s_last_in(s_last_in), .s_ready_in(s_ready_in),
        .s_valid_insert(s_valid_insert), .s_header_insert(s_header_insert),
        .s_keep_insert(s_keep_insert), .s_ready_insert(s_ready_insert),
        .m_valid_in(m_valid_in), .m_data_in(m_data_in), .m_keep_in(m_keep_in),
        .m_last_in(m_last_in), .m_ready_in(m_ready_in),
        .m_valid_insert(m_valid_insert), .m_header_insert(m_header_insert),
        .m_keep_insert(m_keep_insert), .m_ready_insert(m_ready_insert),
        .busy(busy), .grant_id(grant_id), .pkt_count(pkt_count)
    );

    // Three-source instance (non-power-of-2 wrap, counter wrap)
    logic [NS3-1:0]    b_s_valid_in, b_s_last_in, b_s_ready_in, b_s_valid_insert, b_s_ready_insert;
    logic [NS3*DW-1:0] b_s_data_in, b_s_header_insert;
    logic [NS3*BW-1:0] b_s_keep_in, b_s_keep_insert;
    logic              b_m_valid_in, b_m_last_in, b_m_valid_insert, b_busy;
    logic [DW-1:0]     b_m_data_in, b_m_header_insert;
    logic [BW-1:0]     b_m_keep_in, b_m_keep_insert;
    logic [1:0]        b_grant_id;
    logic [15:0]       b_pkt_count;
    logic              b_m_ready_in, b_m_ready_insert;

    axis_insert_header_arb #(.DATA_WD(DW), .NUM_SRC(NS3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .s_valid_in(b_s_valid_in), .s_data_in(b_s_data_in), .s_keep_in(b_s_keep_in),
        .s_last_in(b_s_last_in), .s_ready_in(b_s_ready_in),
        .s_valid_insert(b_s_valid_insert), .s_header_insert(b_s_header_insert),
        .s_keep_insert(b_s_keep_insert), .s_ready_insert(b_s_ready_insert),
        .m_valid_in(b_m_valid_in), .m_data_in(b_m_data_in), .m_keep_in(b_m_keep_in),
        .m_last_in(b_m_last_in), .m_ready_in(b_m_ready_in),
        .m_valid_insert(b_m_valid_insert), .m_header_insert(b_m_header_insert),
        .m_keep_insert(b_m_keep_insert), .m_ready_insert(b_m_ready_insert),
        .busy(b_busy), .grant_id(b_grant_id), .pkt_count(b_pkt_count)
    );

    // Source models
    typedef struct packed {
        logic [DW-1:0] d;
        logic [BW-1:0] k;
        logic          l;
    } beat_t;

    logic [DW-1:0] bdat [NS][8];
    logic [BW-1:0] bkeep[NS][8];
    int            nb[NS];
    int            bi[NS];
    bit            hpend[NS];
    bit            den[NS];
    logic [DW-1:0] hdr[NS];
    logic [BW-1:0] hkp[NS];

    // Scoreboard
    beat_t              exp_beat[$];
    logic [DW+BW-1:0]   exp_hdr[$];
    int                 exp_gnt[$];
    int                 cur_g;
    bit                 prev_busy;
    bit                 mon_en;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drive();
        for (int s = 0; s < NS; s++) begin
            s_valid_insert[s]            = hpend[s];
            s_header_insert[s*DW +: DW]  = hdr[s];
            s_keep_insert[s*BW +: BW]    = hkp[s];
            if (den[s] && bi[s] < nb[s]) begin
                s_valid_in[s]           = 1'b1;
                s_data_in[s*DW +: DW]   = bdat[s][bi[s]];
                s_keep_in[s*BW +: BW]   = bkeep[s][bi[s]];
                s_last_in[s]            = (bi[s] == nb[s] - 1);
            end else begin
                s_valid_in[s]           = 1'b0;
                s_data_in[s*DW +: DW]   = '0;
                s_keep_in[s*BW +: BW]   = '0;
                s_last_in[s]            = 1'b0;
            end
        end
    endtask

    task automatic load_pkt(input int s, input logic [DW-1:0] h, input logic [BW-1:0] hk,
                            input int n, input logic [DW-1:0] base, input logic [BW-1:0] lk,
                            input bit hp, input bit de);
        hdr[s] = h;
        hkp[s] = hk;
        nb[s]  = n;
        bi[s]  = 0;
        for (int j = 0; j < n; j++) begin
            bdat[s][j]  = base + 32'(j);
            bkeep[s][j] = (j == n - 1) ? lk : 4'hF;
        end
        hpend[s] = hp;
        den[s]   = de;
    endtask

    task automatic expect_pkt(input int s);
        beat_t b;
        exp_gnt.push_back(s);
        exp_hdr.push_back({hdr[s], hkp[s]});
        for (int j = 0; j < nb[s]; j++) begin
            b.d = bdat[s][j];
            b.k = bkeep[s][j];
            b.l = (j == nb[s] - 1);
            exp_beat.push_back(b);
        end
    endtask

    task automatic monitor();
        logic [NS-1:0] mask;
        beat_t         e;
        logic [DW+BW-1:0] eh;
        if (!mon_en) return;
        if (busy && !prev_busy) begin
            if (exp_gnt.size() == 0) chk("grant_unexpected", 64'(exp_gnt.size()), 1);
            else begin
                cur_g = exp_gnt.pop_front();
                chk("grant_id", grant_id, cur_g);
            end
        end
        prev_busy = busy;
        mask = busy ? (NS'(1) << cur_g) : '0;
        chk("nongrant_ready", (s_ready_in | s_ready_insert) & ~mask, 0);
        if (!busy) chk("idle_m_valid", {m_valid_in, m_valid_insert}, 0);
        if (m_valid_insert && m_ready_insert) begin
            if (exp_hdr.size() == 0) chk("hdr_unexpected", 64'(exp_hdr.size()), 1);
            else begin
                eh = exp_hdr.pop_front();
                chk("hdr", {m_header_insert, m_keep_insert}, eh);
            end
            for (int s = 0; s < NS; s++)
                if (s_valid_insert[s] && s_ready_insert[s]) hpend[s] = 1'b0;
        end
        if (m_valid_in && m_ready_in) begin
            if (exp_beat.size() == 0) chk("beat_unexpected", 64'(exp_beat.size()), 1);
            else begin
                e = exp_beat.pop_front();
                chk("beat", {m_data_in, m_keep_in, m_last_in}, {e.d, e.k, e.l});
            end
            for (int s = 0; s < NS; s++)
                if (s_valid_in[s] && s_ready_in[s]) bi[s]++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run_idle(input string tag, input int max);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((busy || exp_gnt.size() != 0 || exp_hdr.size() != 0 || exp_beat.size() != 0)
                   && n < max);
        chk({tag, "_drain_q"}, 64'(exp_gnt.size() + exp_hdr.size() + exp_beat.size()), 0);
        chk({tag, "_drain_busy"}, busy, 0);
    endtask

    task automatic clear_model();
        for (int s = 0; s < NS; s++) begin
            hpend[s] = 1'b0;
            den[s]   = 1'b0;
            nb[s]    = 0;
            bi[s]    = 0;
            hdr[s]   = '0;
            hkp[s]   = '0;
        end
        exp_gnt.delete();
        exp_hdr.delete();
        exp_beat.delete();
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst_n  = 1'b0;
        clear_model();
        m_ready_in     = 1'b1;
        m_ready_insert = 1'b1;
        drive();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n     = 1'b1;
        prev_busy = 1'b0;
        mon_en    = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        b_s_valid_in      = '0;
        b_s_valid_insert  = '0;
        b_s_last_in       = 3'b111;
        b_s_data_in       = {32'hC2C2_0002, 32'hC1C1_0001, 32'hC0C0_0000};
        b_s_keep_in       = '1;
        b_s_header_insert = {32'hBEEF_0002, 32'hBEEF_0001, 32'hBEEF_0000};
        b_s_keep_insert   = '1;
        b_m_ready_in      = 1'b1;
        b_m_ready_insert  = 1'b1;
        cur_g = 0;

        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_m_valid", {m_valid_in, m_valid_insert}, 0);
        chk("rst_s_ready", {s_ready_in, s_ready_insert}, 0);

        // 1: single source, header with 4 beats
        load_pkt(0, 32'hFFEE_DDCC, 4'b0111, 4, 32'h1000_0000, 4'b1100, 1, 1);
        expect_pkt(0);
        drive();
        chk("t1_busy_before", busy, 0);
        step();
        chk("t1_busy_latency", busy, 1);
        run_idle("t1", 40);
        chk("t1_pkt_count", pkt_count, 1);

        // 2: three simultaneous requests, round-robin from 0
        do_reset();
        load_pkt(0, 32'hA000_0000, 4'hF, 2, 32'h2000_0000, 4'b1000, 1, 1);
        load_pkt(1, 32'hA111_1111, 4'hF, 2, 32'h2100_0000, 4'b0001, 1, 1);
        load_pkt(3, 32'hA333_3333, 4'hF, 2, 32'h2300_0000, 4'b0011, 1, 1);
        expect_pkt(0);
        expect_pkt(1);
        expect_pkt(3);
        drive();
        n = 0;
        while (pkt_count != 16'd1 && n < 30) begin
            step();
            n++;
        end
        chk("t2_first_done", pkt_count, 1);
        load_pkt(0, 32'hA000_AAAA, 4'hF, 2, 32'h2010_0000, 4'b1111, 1, 1);
        expect_pkt(0);
        drive();
        run_idle("t2", 80);
        chk("t2_pkt_count", pkt_count, 4);

        // 3: data offered before header
        load_pkt(2, 32'hD222_2222, 4'hE, 3, 32'h3200_0000, 4'b0110, 0, 1);
        drive();
        step();
        chk("t3_ready_early0", {busy, s_ready_in[2]}, 0);
        step();
        chk("t3_ready_early1", {busy, s_ready_in[2]}, 0);
        hpend[2] = 1'b1;
        expect_pkt(2);
        drive();
        step();
        chk("t3_grant_latency", busy, 1);
        run_idle("t3", 40);

        // 4: backpressure on both channels
        m_ready_insert = 1'b0;
        load_pkt(1, 32'hB111_1111, 4'h3, 4, 32'h4100_0000, 4'b0001, 1, 1);
        expect_pkt(1);
        drive();
        step();
        step();
        step();
        m_ready_insert = 1'b1;
        m_ready_in     = 1'b0;
        drive();
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t4_hold_stall", busy, 1);
        end
        m_ready_in = 1'b1;
        drive();
        run_idle("t4", 40);

        // 4b: last beat accepted before the header
        m_ready_insert = 1'b0;
        load_pkt(3, 32'hB333_3333, 4'hF, 1, 32'h4300_0000, 4'b1111, 1, 1);
        expect_pkt(3);
        drive();
        step();
        step();
        step();
        chk("t4b_wait_hdr", busy, 1);
        step();
        chk("t4b_wait_hdr2", {busy, m_valid_in}, 2'b10);
        m_ready_insert = 1'b1;
        drive();
        run_idle("t4b", 20);

        // 5: reset mid-packet, then rr_ptr must restart at 0
        load_pkt(2, 32'hE222_2222, 4'hF, 4, 32'h5200_0000, 4'b1111, 1, 1);
        expect_pkt(2);
        drive();
        step();
        step();
        mon_en = 1'b0;
        rst_n  = 1'b0;
        clear_model();
        drive();
        @(posedge clk); #1;
        rst_n     = 1'b1;
        prev_busy = 1'b0;
        mon_en    = 1'b1;
        chk("t5_busy", busy, 0);
        chk("t5_valids", {m_valid_in, m_valid_insert}, 0);
        chk("t5_readys", {s_ready_in, s_ready_insert}, 0);
        load_pkt(0, 32'hF000_0000, 4'hF, 1, 32'h6000_0000, 4'b0101, 1, 1);
        load_pkt(3, 32'hF333_3333, 4'hF, 1, 32'h6300_0000, 4'b1010, 1, 1);
        expect_pkt(0);
        expect_pkt(3);
        drive();
        run_idle("t5", 40);
        chk("t5_pkt_count", pkt_count, 2);

        // 6: three-source wrap and pkt_count wrap
        b_s_valid_insert = 3'b100;
        b_s_valid_in     = 3'b100;
        @(posedge clk); #1;
        chk("t6_gnt2_busy", b_busy, 1);
        chk("t6_gnt2_id", b_grant_id, 2);
        chk("t6_gnt2_hdr", b_m_header_insert, 32'hBEEF_0002);
        @(posedge clk); #1;
        chk("t6_release", {b_busy, b_pkt_count}, 17'h0_0001);
        b_s_valid_insert = 3'b101;
        b_s_valid_in     = 3'b101;
        @(posedge clk); #1;
        chk("t6_wrap_gnt", b_grant_id, 0);
        @(posedge clk); #1;
        b_s_valid_insert = 3'b100;
        b_s_valid_in     = 3'b100;
        @(posedge clk); #1;
        chk("t6_next_gnt", b_grant_id, 2);
        @(posedge clk); #1;
        b_s_valid_insert = 3'b000;
        b_s_valid_in     = 3'b000;
        chk("t6_count3", b_pkt_count, 3);

        @(negedge clk);
        force dut3.pkt_cnt_q = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut3.pkt_cnt_q;
        chk("t6_count_preset", b_pkt_count, 16'hFFFF);
        @(posedge clk); #1;
        b_s_valid_insert = 3'b010;
        b_s_valid_in     = 3'b010;
        @(posedge clk); #1;
        chk("t6_wrap_pkt_busy", b_busy, 1);
        @(posedge clk); #1;
        b_s_valid_insert = 3'b000;
        b_s_valid_in     = 3'b000;
        chk("t6_count_wrap", b_pkt_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/axis_insert_header_arb.md
# axis_insert_header_arb

Round-robin packet scheduler that shares one `axi_stream_insert_header` engine between `NUM_SRC` requesters. Each requester offers a header (insert channel) and a packet (data channel). The arbiter grants one requester per packet and holds the grant until both its header and its last data beat have been accepted by the engine. It sits directly upstream of the engine and forwards both channels combinationally once a grant is registered.

## Interface
- `DATA_WD`, 32, data/header width in bits
- `DATA_BYTE_WD`, `DATA_WD/8`, keep width
- `NUM_SRC`, 4, number of requesters (2..16)
- `SRC_WD`, `$clog2(NUM_SRC)`, width of the grant index
- `clk` in 1, single clock
- `rst_n` in 1, synchronous, active-low reset
- `s_valid_in` in `NUM_SRC`, per-source data valid
- `s_data_in` in `NUM_SRC*DATA_WD`, source i occupies bits `[i*DATA_WD +: DATA_WD]`
- `s_keep_in` in `NUM_SRC*DATA_BYTE_WD`, packed like data
- `s_last_in` in `NUM_SRC`, per-source last beat
- `s_ready_in` out `NUM_SRC`, per-source data ready
- `s_valid_insert` in `NUM_SRC`, per-source header valid; this is the request
- `s_header_insert` in `NUM_SRC*DATA_WD`, packed headers
- `s_keep_insert` in `NUM_SRC*DATA_BYTE_WD`, packed header keeps
- `s_ready_insert` out `NUM_SRC`, per-source header ready
- `m_valid_in`, `m_data_in`, `m_keep_in`, `m_last_in` out, 1/`DATA_WD`/`DATA_BYTE_WD`/1, to the engine data input
- `m_ready_in` in 1, engine data ready
- `m_valid_insert`, `m_header_insert`, `m_keep_insert` out, 1/`DATA_WD`/`DATA_BYTE_WD`, to the engine insert input
- `m_ready_insert` in 1, engine header ready
- `busy` out 1, a grant is held
- `grant_id` out `SRC_WD`, index of the current or last granted source
- `pkt_count` out 16, number of completed packets; wraps from 0xFFFF to 0

## Operation

**States**
- `IDLE`: no grant.
- `ACTIVE`: grant held. Two sub-flags, `hdr_done` and `last_done`, both cleared on entry.

**Arbitration (IDLE)**
- Request vector is `s_valid_insert`. Data valid alone is not a request.
- Search order is `rr_ptr`, `rr_ptr+1`, … modulo `NUM_SRC`. The first set bit wins.
- On a win: `grant_id` ← winner, `rr_ptr` ← (winner+1) mod `NUM_SRC`, go to `ACTIVE`.
- Wrap at `NUM_SRC-1` → 0, including non-power-of-2 `NUM_SRC`.

**Forwarding (ACTIVE, g = `grant_id`)**
- Header path is open while `!hdr_done`:
  - `m_valid_insert = s_valid_insert[g]`
  - `m_header_insert`, `m_keep_insert` come from slice g
  - `s_ready_insert[g] = m_ready_insert`
- Data path is open while `!last_done`:
  - `m_valid_in = s_valid_in[g]`
  - data, keep and last come from slice g
  - `s_ready_in[g] = m_ready_in`
- Header handshake (`m_valid_insert & m_ready_insert`) sets `hdr_done`.
- Data handshake with `m_last_in` set sets `last_done`.
- Leave for `IDLE` on the edge where `hdr_done` and `last_done` are both true, counting flags set in the same cycle. `pkt_count` increments on that edge.

**Blocking rules**
- Non-granted sources: `s_ready_in` = 0 and `s_ready_insert` = 0 at all times.
- Closed paths drive valid 0 and ready 0.
- The mux outputs `m_data_in`, `m_keep_in`, `m_header_insert`, `m_keep_insert` drive 0 when their path is closed or in `IDLE`.
- A header offered by the granted source after `hdr_done` is not forwarded; it is arbitrated later.
- A source asserting data before its header receives no ready until it is granted.

## Timing
- Reset (`rst_n` = 0 at a clk edge) sets:
  - state `IDLE`, `busy` 0, `grant_id` 0, `rr_ptr` 0, `pkt_count` 0
  - `hdr_done` 0, `last_done` 0
  - all `m_valid_*` 0, all `s_ready_*` 0
- Reset mid-packet abandons the grant immediately; there is no drain.
- Grant latency: a request seen in `IDLE` at edge N gives `busy`=1 and open paths from cycle N+1.
- Release: the completion edge returns to `IDLE`. At least one `IDLE` cycle separates packets, so back-to-back throughput is one dead cycle per packet.
- All `m_*` outputs and `s_ready_*` are combinational from the registered state plus the inputs. There is no added beat latency.
- Valid must never depend on ready. Payload held under backpressure is passed straight through, so stability follows the source's own behaviour.

## Test plan
1. Single source 0: header 0xFFEEDDCC/keep 0111 together with 4 data beats, last keep 1100, `m_ready_*`=1.
   - `busy` rises 1 cycle after request.
   - Engine sees the header once and all 4 beats unchanged.
   - `pkt_count`=1, then `busy`=0.
2. Sources 0, 1 and 3 request in the same cycle with `rr_ptr`=0.
   - Grant order is 0, 1, 3.
   - Source 0 is next granted only after 3 completes.
   - Non-granted ready stays 0 throughout.
3. Data-before-header: source 2 asserts `s_valid_in` 2 cycles before `s_valid_insert`.
   - `s_ready_in[2]`=0 until the grant.
   - Grant follows the header by one cycle.
4. Backpressure: `m_ready_in`=0 for 3 cycles mid-packet, and `m_ready_insert` delayed 2 cycles after the grant.
   - Grant is held.
   - The beat is forwarded exactly once per handshake.
   - Exit only after both done flags.
5. Reset asserted for one cycle while `ACTIVE` mid-packet.
   - Next cycle: `busy`=0, all valids/readys 0, `rr_ptr`=0.
   - A new request is granted normally.
6. `NUM_SRC`=3, source 2 granted, then sources 0 and 2 request.
   - `rr_ptr` wraps to 0, so source 0 wins.
   - Also drive `pkt_count` from 0xFFFF through one more packet and check it wraps to 0.
